// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Holds source count, address/data widths, the writeback request struct
// and the grant-to-index helper used by the round-robin pointer (RR_ARB_EN).
package regfile_wb_arbiter_pkg;

  localparam int NUM_SRC    = 3;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  // Pointer value after reset: "last granted = 2" puts source 0 first.
  localparam logic [1:0] RR_PTR_RESET = 2'd2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Convert a one-hot grant into the index of the granted source.
  function automatic logic [1:0] gnt_to_idx(input logic [NUM_SRC-1:0] gnt);
    logic [1:0] idx;
    idx = 2'd0;
    if (gnt[1]) idx = 2'd1;
    if (gnt[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Writeback arbiter: picks one requester per cycle (round-robin with RR_ARB_EN, else 0>1>2).
// Latency: grant is combinational from the request vector and the pointer.
// Backpressure: ungranted requesters simply see gnt_o low and must hold their request.
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req_i,
  output logic [NUM_SRC-1:0] gnt_o
);

`ifdef RR_ARB_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  // Search starts one past the last granted source and wraps.
  always_comb begin
    gnt_o = '0;
    case (ptr_q)
      2'd0: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      2'd1: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

  // Pointer remembers the last winner; it only moves when someone is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_o) ptr_d = gnt_to_idx(gnt_o);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= RR_PTR_RESET;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest index wins, no state.
  always_comb begin
    gnt_o = '0;
    if      (req_i[0]) gnt_o = 3'b001;
    else if (req_i[1]) gnt_o = 3'b010;
    else if (req_i[2]) gnt_o = 3'b100;
  end

  // Clock and reset only feed the pointer, which does not exist here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates writeback sources onto one register-file write port and keeps the pending scoreboard.
// Latency: grant in cycle N appears on rd_* in N+1; busy[r] clears at the end of N+1.
// Backpressure: one grant per cycle via src_ready; losers hold valid (RR_ARB_EN selects round-robin).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3
)
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SRC-1:0]                    src_valid,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]    src_addr,
  input  logic [NUM_SRC-1:0][XLEN-1:0]          src_data,
  output logic [NUM_SRC-1:0]                    src_ready,
  input  logic                                  issue_valid,
  input  logic [REG_ADDR_W-1:0]                 issue_addr,
  output logic [NUM_REGS-1:0]                   busy,
  output logic                                  rd_we,
  output logic [REG_ADDR_W-1:0]                 rd_addr,
  output logic [XLEN-1:0]                       rd_data
);

  logic [NUM_SRC-1:0]  req_gated;
  logic [NUM_SRC-1:0]  grant;
  wb_req_t             wb_sel;
  wb_req_t             wb_d;
  wb_req_t             wb_q;
  logic                rd_we_d;
  logic                rd_we_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_q;

  // Nothing is granted while in reset, so a pending request is never accepted.
  assign req_gated = rst ? '0 : src_valid;

  rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_gated),
    .gnt_o (grant)
  );

  assign src_ready = grant;

  // Mux the granted source's request; grant is one-hot so at most one term hits.
  always_comb begin
    wb_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        wb_sel.addr = src_addr[i];
        wb_sel.data = src_data[i];
      end
    end
  end

  // Writes to x0 are accepted but dropped; the port holds its last address/data otherwise.
  always_comb begin
    rd_we_d = (|grant) && (wb_sel.addr != '0);
    wb_d    = rd_we_d ? wb_sel : wb_q;
  end

  // Registered register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      rd_we_q <= rd_we_d;
      wb_q    <= wb_d;
    end
  end

  // Scoreboard: clear on the write landing, then set on issue so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (rd_we_q) busy_d[wb_q.addr] = 1'b0;
    if (issue_valid && (issue_addr != '0)) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rd_we   = rd_we_q;
  assign rd_addr = wb_q.addr;
  assign rd_data = wb_q.data;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (works with or without RR_ARB_EN).
// A behavioural model is compared against the DUT every cycle at the falling edge,
// and directed scenarios add hand-computed literal expectations.
module tb_regfile_wb_arbiter;

  logic             clk;
  logic             rst;
  logic [2:0]       src_valid;
  logic [2:0][4:0]  src_addr;
  logic [2:0][31:0] src_data;
  logic [2:0]       src_ready;
  logic             issue_valid;
  logic [4:0]       issue_addr;
  logic [31:0]      busy;
  logic             rd_we;
  logic [4:0]       rd_addr;
  logic [31:0]      rd_data;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit          m_ok    = 0;
  bit          m_known = 0;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  int          m_last;
  int          cyc = 0;

  regfile_wb_arbiter #(.NUM_SRC(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_addr    (src_addr),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .busy        (busy),
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Which source the arbitration rule picks, or -1 when none is valid.
  function automatic int pick_src(input logic [2:0] v, input int last);
`ifdef RR_ARB_EN
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (v[idx]) return idx;
    end
`else
    for (int i = 0; i < 3; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  // Compare DUT against model at the falling edge, advance model, then return at posedge+1.
  task automatic step();
    int          p;
    logic [2:0]  exp_rdy;
    @(negedge clk);
    p = rst ? -1 : pick_src(src_valid, m_last);
    exp_rdy = (p < 0) ? 3'b000 : (3'b001 << p);
    if (m_ok) begin
      chk("model_src_ready", 32'(src_ready), 32'(exp_rdy));
      chk("model_rd_we",     32'(rd_we),     32'(m_we));
      chk("model_busy",      busy,           m_busy);
      if (m_known) begin
        chk("model_rd_addr", 32'(rd_addr), 32'(m_addr));
        chk("model_rd_data", rd_data,      m_data);
      end
    end
    if (rst) begin
      m_we = 0; m_addr = 0; m_data = 0; m_busy = 0; m_last = 2;
      m_known = 1; m_ok = 1;
    end else begin
      if (m_we) m_busy[m_addr] = 1'b0;
      if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      if (p >= 0) begin
        m_last = p;
        if (src_addr[p] != 0) begin
          m_we = 1; m_addr = src_addr[p]; m_data = src_data[p]; m_known = 1;
        end else begin
          m_we = 0; m_known = 0;
        end
      end else begin
        m_we = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    src_valid   = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
    src_valid[i] = 1'b1;
    src_addr[i]  = a;
    src_data[i]  = d;
  endtask

  initial begin
    logic [31:0] exp_rdy;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    src_addr = '0;
    src_data = '0;
    idle();
    rst = 1'b1;
    // A request pending during reset must not be granted.
    set_src(0, 5'd3, 32'hDEAD0003);
    @(posedge clk); #1;
    step();
    chk("rst_src_ready", 32'(src_ready), 32'h0);
    step();
    chk("rst_rd_we", 32'(rd_we), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    chk("rst_busy", busy, 32'h0);
    idle();
    rst = 1'b0;
    step();

    // Basic write
    set_src(0, 5'd1, 32'h11111111);
    #1 chk("basic_ready", 32'(src_ready), 32'h1);
    step();
    idle();
    chk("basic_rd_we", 32'(rd_we), 32'h1);
    chk("basic_rd_addr", 32'(rd_addr), 32'h1);
    chk("basic_rd_data", rd_data, 32'h11111111);
    step();
    chk("basic_idle_we", 32'(rd_we), 32'h0);
    chk("basic_hold_addr", 32'(rd_addr), 32'h1);

    // Scoreboard: issue in cycle 0, write granted in cycle 3
    issue_valid = 1'b1; issue_addr = 5'd5;
    step();
    idle();
    chk("sb_busy_c1", 32'(busy[5]), 32'h1);
    step();
    step();
    set_src(1, 5'd5, 32'h00000055);
    step();
    idle();
    chk("sb_busy_c4", 32'(busy[5]), 32'h1);
    chk("sb_rd_addr_c4", 32'(rd_addr), 32'h5);
    step();
    chk("sb_busy_c5", 32'(busy[5]), 32'h0);

    // Set and clear on the same edge: set wins
    issue_valid = 1'b1; issue_addr = 5'd5;
    step();
    idle();
    set_src(2, 5'd5, 32'h0000005A);
    step();
    idle();
    chk("sbw_land_we", 32'(rd_we), 32'h1);
    issue_valid = 1'b1; issue_addr = 5'd5;
    step();
    idle();
    chk("sbw_set_wins", 32'(busy[5]), 32'h1);
    step();
    chk("sbw_still_busy", 32'(busy[5]), 32'h1);
    set_src(0, 5'd5, 32'h0000005B);
    step();
    idle();
    step();
    chk("sbw_cleared", 32'(busy[5]), 32'h0);

    // Write to x0 is accepted and dropped
    set_src(2, 5'd0, 32'hFFFFFFFF);
    #1 chk("x0_ready", 32'(src_ready), 32'h4);
    step();
    idle();
    chk("x0_rd_we", 32'(rd_we), 32'h0);
    chk("x0_busy", busy, 32'h0);
    step();

    // All three sources continuously valid
    set_src(0, 5'd1, 32'hA);
    set_src(1, 5'd2, 32'hB);
    set_src(2, 5'd3, 32'hC);
    for (int k = 0; k < 6; k++) begin
`ifdef RR_ARB_EN
      exp_rdy  = 32'h1 << (k % 3);
      exp_addr = 32'((k % 3) + 1);
      exp_data = 32'hA + 32'(k % 3);
`else
      exp_rdy  = 32'h1;
      exp_addr = 32'h1;
      exp_data = 32'hA;
`endif
      #1 chk("fair_ready", 32'(src_ready), exp_rdy);
      step();
      chk("fair_rd_addr", 32'(rd_addr), exp_addr);
      chk("fair_rd_data", rd_data, exp_data);
    end
    idle();
    step();

    // Two sources to one register are served in grant order
    set_src(1, 5'd9, 32'h91);
    set_src(2, 5'd9, 32'h92);
    #1 chk("same_ready1", 32'(src_ready), 32'h2);
    step();
    src_valid[1] = 1'b0;
    chk("same_data1", rd_data, 32'h91);
    #1 chk("same_ready2", 32'(src_ready), 32'h4);
    step();
    idle();
    chk("same_data2", rd_data, 32'h92);
    chk("same_addr2", 32'(rd_addr), 32'h9);
    step();

    // Reset in the cycle after a grant to x7 with busy[7] set
    issue_valid = 1'b1; issue_addr = 5'd7;
    step();
    idle();
    chk("rm_busy7", 32'(busy[7]), 32'h1);
    set_src(1, 5'd7, 32'h77);
    #1 chk("rm_ready", 32'(src_ready), 32'h2);
    step();
    idle();
    chk("rm_pre_rst_we", 32'(rd_we), 32'h1);
    rst = 1'b1;
    set_src(0, 5'd1, 32'hA);
    set_src(1, 5'd2, 32'hB);
    set_src(2, 5'd3, 32'hC);
    #1 chk("rm_rst_ready", 32'(src_ready), 32'h0);
    step();
    chk("rm_rst_we", 32'(rd_we), 32'h0);
    chk("rm_rst_busy", busy, 32'h0);
    chk("rm_rst_ready2", 32'(src_ready), 32'h0);
    step();
    rst = 1'b0;
    #1 chk("rm_first_ready", 32'(src_ready), 32'h1);
    step();
    chk("rm_first_addr", 32'(rd_addr), 32'h1);
    chk("rm_first_data", rd_data, 32'hA);
    idle();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 3, giving the number of writeback requesters (fixed at 3 in this release).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port src_valid  input  3  per-source writeback request.
REQ-005 The block SHALL have port src_addr  input  3x5  per-source destination register.
REQ-006 The block SHALL have port src_data  input  3x32  per-source writeback data.
REQ-007 The block SHALL have port src_ready  output  3  per-source grant, one-hot or zero.
REQ-008 The block SHALL have port issue_valid  input  1  issue stage marks a register pending.
REQ-009 The block SHALL have port issue_addr  input  5  register to mark pending.
REQ-010 The block SHALL have port busy  output  32  scoreboard, one pending bit per register.
REQ-011 The block SHALL have ports rd_we (output, 1), rd_addr (output, 5) and rd_data (output, 32), which drive the register-file write port.

Function
REQ-012 src_ready SHALL be combinational from src_valid and arbiter state.
- At most one bit is set.
- No bit is set unless its src_valid is set.
REQ-013 A transfer SHALL occur on source i in any cycle where src_valid[i] and src_ready[i] are both high.
REQ-014 A source SHALL hold src_valid, src_addr and src_data stable until it is granted; the block does not retain ungranted requests.
REQ-015 The write port SHALL be registered, giving one cycle of latency.
- A grant in cycle N drives rd_we, rd_addr and rd_data in cycle N+1.
- With no grant in cycle N, rd_we=0 in cycle N+1, and rd_addr and rd_data hold their previous values.
REQ-016 If some source is valid, the block SHALL grant exactly one source every cycle, for sustained throughput of one write per cycle.
REQ-017 A granted request with src_addr=0 SHALL be accepted and then dropped: rd_we=0 in N+1, with no scoreboard effect.
REQ-018 A grant to register r≠0 in cycle N SHALL clear busy[r] at the end of cycle N+1, so busy[r] reads 0 from N+2, the first cycle the register file read returns the new value.
REQ-019 issue_valid with issue_addr=r≠0 SHALL set busy[r] on the next edge; issue_addr=0 SHALL be ignored, and busy[0] is constantly 0.
REQ-020 If a set and a clear of the same register coincide on one edge, the set SHALL win, because a newer producer is outstanding.
REQ-021 Multiple sources targeting the same register SHALL be served in grant order, with no merging.

Reset
REQ-022 While rst is high, on each clk edge the block SHALL set rd_we=0, rd_addr=0, rd_data=0, busy=0 and the round-robin pointer to 2, which gives source 0 the highest priority first.
REQ-023 src_ready SHALL be 0 in any cycle where rst is high.
- A request pending at reset is neither granted nor written.
- A write already registered before reset is discarded.

Configuration
REQ-024 With RR_ARB_EN defined, arbitration SHALL be round-robin.
- Search order starts at (last granted + 1) mod 3.
- The pointer updates only on a grant.
- A continuously valid source waits at most 2 cycles.
REQ-025 Without RR_ARB_EN, arbitration SHALL be fixed priority with source 0 > 1 > 2, and the pointer register is not built.

Structure
REQ-026 A shared package SHALL hold:
- the constants NUM_SRC=3, REG_ADDR_W=5, XLEN=32 and NUM_REGS=32;
- a packed struct type wb_req_t {addr, data}.
REQ-027 The arbiter SHALL be a separate sub-module, rr_arbiter, with request vector in and one-hot grant out.
- It contains the pointer and the RR_ARB_EN selection.
- The top level holds the write-port register and the scoreboard.

Verification
REQ-028 Scenario, basic write: src0 valid with addr=1, data=32'h11111111 in cycle N -> src_ready=3'b001 in N; rd_we=1, rd_addr=1, rd_data=32'h11111111 in N+1; idle in N+2.
REQ-029 Scenario, round-robin fairness (RR_ARB_EN defined): all three sources valid continuously, with addr 1/2/3 and data 32'hA/32'hB/32'hC -> grants 0,1,2,0,... one per cycle, and rd_addr sequence 1,2,3,1.
REQ-030 Scenario, fixed priority (RR_ARB_EN undefined): same stimulus as REQ-029 -> src0 granted every cycle, and src1/src2 are never granted while src0 is valid.
REQ-031 Scenario, scoreboard: issue_valid with addr=5 in cycle 0; src1 writes addr=5 in cycle 3 -> busy[5]=1 during cycles 1–4, busy[5]=0 from cycle 5.
- A further sub-case: issue of addr=5 in the same cycle that its write lands -> busy[5] stays 1.
REQ-032 Scenario, x0: src2 valid with addr=0, data=32'hFFFFFFFF -> src_ready[2]=1, rd_we=0 in the next cycle, busy=0.
REQ-033 Scenario, reset mid-operation: rst asserted in the cycle after a grant to addr=7, with busy[7]=1 -> rd_we=0, busy=0, src_ready=0 during reset; after release, src0 is granted first when all sources are valid.
